// File: rtl/imem_loader.sv
// imem_loader: the writer side of the instruction-memory interface.
// It receives a framed byte stream: LEN_HI, LEN_LO, 4*N data bytes (each word
// MSB first), then a CSUM byte. It assembles big-endian words and writes them
// to consecutive word addresses. The processor is held off until the whole
// image has been written and its checksum matches.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_written
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // Capacity in words. The length field is compared against it at 17 bits, so
  // that N == 2^16 - 1 still compares correctly when ADDR_W is 16.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;           // word count N from the header
  logic [7:0]        xor_q, xor_d;           // running XOR of the frame bytes
  logic [1:0]        idx_q, idx_d;           // byte index within the current word
  logic [15:0]       word_cnt_q, word_cnt_d; // words fully received so far
  logic [23:0]       asm_q, asm_d;           // the first three bytes of the current word
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       ww_q, ww_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [15:0]       n_len;

  // Handshake: the block is ready in the four receive states and in no other.
  always_comb begin
    in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
               (state_q == S_DATA)   || (state_q == S_CSUM);
    accept   = in_valid && in_ready;
  end

  // Next-state logic for the frame FSM, the word assembler and the write port.
  always_comb begin
    // NOTE: every _d gets its hold value before the case. Each branch then only
    // changes what it needs, and no path can leave a signal unassigned, which
    // would infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    xor_d      = xor_q;
    idx_d      = idx_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    we_d       = 1'b0;             // the write strobe lasts one cycle unless it is set again
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ww_d       = ww_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    n_len      = {len_q[15:8], in_data};

    // Retire the write issued in the previous cycle. The address wraps
    // naturally at 2^ADDR_W.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
      ww_d   = ww_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_HI;
          xor_d      = 8'h00;
          idx_d      = 2'd0;
          word_cnt_d = 16'd0;
          addr_d     = '0;
          ww_d       = 16'd0;
          hold_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {in_data, len_q[7:0]};
          xor_d   = xor_q ^ in_data;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = n_len;
          xor_d = xor_q ^ in_data;
          if ({1'b0, n_len} > CAPACITY) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n_len == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d = xor_q ^ in_data;
          asm_d = {asm_q[15:0], in_data};
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // The word is complete: launch its write for the next cycle at the
            // current address.
            we_d       = 1'b1;
            wdata_d    = {asm_q, in_data};
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == len_q) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers. An asynchronous reset drops any pending write at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together from the values before the edge, with no ordering races.
    if (!RST_N) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      xor_q      <= 8'h00;
      idx_q      <= 2'd0;
      word_cnt_q <= 16'd0;
      asm_q      <= 24'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      ww_q       <= 16'd0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      xor_q      <= xor_d;
      idx_q      <= idx_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ww_q       <= ww_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign imem_we       = we_q;
  assign imem_addr     = addr_q;
  assign imem_wdata    = wdata_q;
  assign cpu_hold      = hold_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. A table of directed frames is applied in a loop.
// Hand-written sequences then cover reset in the middle of a word and reset
// during a write strobe.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int BUDGET = 100;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [15:0]       words_written;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_written(words_written)
  );

  always #5 CLK = ~CLK;

  int vec_cnt = 0;
  int miscmp = 0;
  int rdy_viol = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  // Record every write cycle, and flag in_ready seen high in DONE or ERR.
  always @(negedge CLK) begin
    if (RST_N && imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (RST_N && (done || err) && in_ready) rdy_viol++;
  end

  typedef struct {
    string       name;
    logic [15:0] len;
    int          seed;
    bit          stop_after_len;
    bit          use_csum;
    logic [7:0]  csum;
    bit          gaps;
    bit          strobe_chk;
    int          poke_start_at;
    bit          exp_done;
    bit          exp_err;
    int          exp_ww;
    int          exp_writes;
    int          exp_addr_end;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string name, logic [15:0] len, int seed, bit stop, bit use_c,
                              logic [7:0] c, bit gaps, bit sc, int poke, bit ed, bit ee,
                              int eww, int ewr, int eaddr);
    vec_t v;
    v.name = name; v.len = len; v.seed = seed; v.stop_after_len = stop;
    v.use_csum = use_c; v.csum = c; v.gaps = gaps; v.strobe_chk = sc;
    v.poke_start_at = poke; v.exp_done = ed; v.exp_err = ee; v.exp_ww = eww;
    v.exp_writes = ewr; v.exp_addr_end = eaddr;
    return v;
  endfunction

  function automatic logic [31:0] word_of(int seed, int i);
    if (seed == 0) return (i == 0) ? 32'h12345678 : 32'h9ABCDEF0;
    return {8'(seed), 8'(i), 8'(i >> 8), 8'(i * 7 + seed)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_words_written"}, words_written, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // Present one byte, optionally after random idle cycles, and return just
  // after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    int g = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 0 && g < 4) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge CLK); #1;
        g++;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < BUDGET) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!in_ready) begin
      vec_cnt++;
      miscmp++;
      $display("FAIL send_byte_timeout: in_ready got 0, expected 1 within %0d cycles", BUDGET);
    end else begin
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    logic [7:0]  bytes[$];
    logic [7:0]  x;
    logic [31:0] w;
    int          nw;
    int          nbad;
    int          lim;
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    check({v.name, "_hold_after_start"}, cpu_hold, 1);
    check({v.name, "_done_cleared"}, done, 0);
    check({v.name, "_err_cleared"}, err, 0);
    check({v.name, "_ww_cleared"}, words_written, 0);

    nw = v.stop_after_len ? 0 : int'(v.len);
    bytes.push_back(v.len[15:8]);
    bytes.push_back(v.len[7:0]);
    for (int i = 0; i < nw; i++) begin
      w = word_of(v.seed, i);
      bytes.push_back(w[31:24]);
      bytes.push_back(w[23:16]);
      bytes.push_back(w[15:8]);
      bytes.push_back(w[7:0]);
    end
    if (!v.stop_after_len) begin
      x = 8'h00;
      foreach (bytes[k]) x ^= bytes[k];
      bytes.push_back(v.use_csum ? v.csum : x);
    end

    for (int k = 0; k < bytes.size(); k++) begin
      if (k == v.poke_start_at) start = 1'b1;
      send_byte(bytes[k], v.gaps);
      start = 1'b0;
      if (v.strobe_chk && k >= 2 && k < 2 + 4 * nw && ((k - 2) % 4) == 3) begin
        check({v.name, "_strobe_we"}, imem_we, 1);
        check({v.name, "_strobe_addr"}, imem_addr, (k - 2) / 4);
        check({v.name, "_strobe_data"}, imem_wdata, word_of(v.seed, (k - 2) / 4));
      end
    end

    repeat (3) @(posedge CLK);
    #1;
    check({v.name, "_done"}, done, v.exp_done);
    check({v.name, "_err"}, err, v.exp_err);
    check({v.name, "_cpu_hold"}, cpu_hold, v.exp_done ? 0 : 1);
    check({v.name, "_words_written"}, words_written, v.exp_ww);
    check({v.name, "_addr_end"}, imem_addr, v.exp_addr_end);
    check({v.name, "_in_ready_idle"}, in_ready, 0);
    check({v.name, "_write_count"}, wr_addr_q.size(), v.exp_writes);
    nbad = 0;
    lim  = (wr_addr_q.size() < v.exp_writes) ? wr_addr_q.size() : v.exp_writes;
    for (int i = 0; i < lim; i++) begin
      if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== word_of(v.seed, i)) nbad++;
    end
    check({v.name, "_bad_writes"}, nbad, 0);
  endtask

  initial begin
    vecs[0] = mk("ok2",     16'd2,      0, 0, 1, 8'h02, 0, 1, -1, 1, 0, 2,    2,    2);
    vecs[1] = mk("badcsum", 16'd2,      0, 0, 1, 8'h03, 0, 0, -1, 0, 1, 2,    2,    2);
    vecs[2] = mk("toolong", 16'h0401,   1, 1, 0, 8'h00, 0, 0, -1, 0, 1, 0,    0,    0);
    vecs[3] = mk("empty",   16'd0,      1, 0, 1, 8'h00, 0, 0, -1, 1, 0, 0,    0,    0);
    vecs[4] = mk("w16",     16'd16,     5, 0, 0, 8'h00, 0, 0,  9, 1, 0, 16,   16,   16);
    vecs[5] = mk("w16gap",  16'd16,     5, 0, 0, 8'h00, 1, 0, -1, 1, 0, 16,   16,   16);
    vecs[6] = mk("full",    16'd1024,   3, 0, 0, 8'h00, 0, 0, -1, 1, 0, 1024, 1024, 0);

    // Reset state.
    #12;
    check_reset_outputs("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check_reset_outputs("idle");

    foreach (vecs[i]) run_vector(vecs[i]);

    // Reset after the second byte of the first word: no write may appear.
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    RST_N = 1'b0;
    #2;
    check_reset_outputs("rst_midword");
    repeat (2) @(posedge CLK);
    #1;
    check("rst_midword_no_write", wr_addr_q.size(), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Reset while the write strobe is high: the strobe drops at once.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    check("pre_rst_we", imem_we, 1);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("rst_strobe");
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // A full, valid frame after reset loads from address 0.
    run_vector(vecs[0]);

    check("in_ready_outside_rx", rdy_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The processor only reads instruction memory; this block fills it at run time instead of from a file preload.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to consecutive word addresses and holds the processor off until a checksum-verified image is in place.

Parameters:
- ADDR_W, 10, word-address width; capacity is 2^ADDR_W words (1024 by default).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- start  input  1  pulse; begins a load when the block is in IDLE, DONE or ERR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  instruction word.
- cpu_hold  output  1  processor must stall or stay in reset while high.
- done  output  1  image loaded and checksum matched.
- err  output  1  length overflow or checksum mismatch.
- words_written  output  16  number of words written in the current or last load.

Behaviour:
- Frame format: LEN_HI, LEN_LO (N = 16-bit word count, MSB first), then 4N data bytes with each word's MSB first, then one CSUM byte.
- CSUM must equal the XOR of every preceding byte in the frame, length bytes included.
- A byte is accepted on a rising edge where in_valid && in_ready. in_ready is combinational from state only: high in LEN_HI, LEN_LO, DATA and CSUM; low otherwise.
- Reset values: state = IDLE, in_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_hold = 1, done = 0, err = 0, words_written = 0. The internal byte index, word counter and running XOR are also 0.
- State IDLE: start moves to LEN_HI. The XOR, byte index, address and words_written are cleared, and done and err are cleared.
- State LEN_HI: on accept, latch N[15:8] and go to LEN_LO.
- State LEN_LO: on accept, latch N[7:0].
  - If N > 2^ADDR_W, go to ERR.
  - If N == 0, go to CSUM.
  - Otherwise go to DATA.
- State DATA: bytes shift into a 32-bit assembly register, left shift with the new byte in [7:0], and the byte index counts 0..3.
  - On acceptance of byte index 3: the next cycle drives imem_we = 1 for exactly one cycle, with imem_wdata = the assembled word and imem_addr = the current word address.
  - After that write cycle, imem_addr increments and words_written increments.
  - After the Nth word is accepted, go to CSUM. In-DATA throughput is 1 byte per cycle; the write pipeline does not backpressure.
- State CSUM: on accept, compare the byte with the running XOR. Match goes to DONE; mismatch goes to ERR.
- State DONE: done = 1, cpu_hold = 0. Outputs hold until start or reset.
- State ERR: err = 1, cpu_hold stays 1. Partially written memory is not rolled back.
- cpu_hold rises to 1 in the cycle after start is accepted, and falls only on the edge that enters DONE.
- start while in LEN_HI, LEN_LO, DATA or CSUM is ignored.
- Address wrap: with N = 2^ADDR_W, the last write is at address 2^ADDR_W - 1. imem_addr then wraps to 0, but no further write is issued.
- in_valid low stalls a state indefinitely and there is no timeout. in_data is ignored when not accepted.
- RST_N low at any time, including mid-word or during a write strobe, returns immediately to the reset values. A pending imem_we is dropped.

Test Plan:
- Reset then start; stream 00 02 12 34 56 78 9A BC DE F0 and CSUM = 00^02^12^34^56^78^9A^BC^DE^F0 = 0x02.
  - Required: writes addr 0 = 0x12345678 and addr 1 = 0x9ABCDEF0, one imem_we pulse each, one cycle after the 4th byte.
  - Required: done = 1, cpu_hold = 0, words_written = 2.
- Same frame with CSUM 0x03 -> err = 1, done = 0, cpu_hold = 1, and both words are still written.
- Length 0x0401 with ADDR_W = 10 -> ERR right after LEN_LO, with no imem_we pulses.
- N = 0 with frame 00 00 00 -> done = 1 and no writes.
- Random in_valid gaps, about 50% duty, over a 16-word frame -> identical writes and addresses to the gap-free run. in_ready is never high outside the four receive states.
- RST_N pulsed low after byte 2 of word 1 -> all outputs return to reset values with no imem_we pulse.
  - Required: a following start plus a full valid frame loads correctly from addr 0.
